// File: rtl/slave_port_pkg.sv
// Shared serial-bus definitions for the slave port: FSM encoding, mode codes
// common with the master port, and a small sizing helper.
package slave_port_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_WDATA = 3'd2,
    S_MEMWR = 3'd3,
    S_MEMRD = 3'd4,
    S_RWAIT = 3'd5,
    S_RDATA = 3'd6
  } sp_state_t;

  // Slave-select bits, decoded upstream of this block.
  localparam int SLAVE_ADDR_WIDTH = 4;

  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/slave_port.sv
// Serial-bus slave responder: deserializes address/write data LSB first,
// drives the slave memory, and serializes read data back with a valid strobe.
module slave_port
  import slave_port_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  swdata,
  input  logic                  smode,
  input  logic                  mvalid,
  output logic                  srdata,
  output logic                  svalid,
  output logic [ADDR_WIDTH-1:0] smemaddr,
  output logic [DATA_WIDTH-1:0] smemwdata,
  output logic                  smemwen,
  output logic                  smemren,
  input  logic [DATA_WIDTH-1:0] smemrdata,
  input  logic                  smemrvalid,
  output logic                  sbusy
);

  localparam int CNT_W = $clog2(max_int(ADDR_WIDTH, DATA_WIDTH) + 1);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  sp_state_t             state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  mode_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  srdata_q;
  logic                  svalid_q;
  logic                  wen_q;
  logic                  ren_q;
  logic                  busy_q;

  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] wdata_d;
  logic [DATA_WIDTH-1:0] rdata_d;

  // Bits enter at the MSB and walk down, so after a full word the first
  // (LSB) bit received sits at position 0.
  always_comb begin
    addr_d                 = addr_q >> 1;
    addr_d[ADDR_WIDTH-1]   = swdata;
    wdata_d                = wdata_q >> 1;
    wdata_d[DATA_WIDTH-1]  = swdata;
    rdata_d                = rdata_q >> 1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mode_q   <= MODE_READ;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      srdata_q <= 1'b0;
      svalid_q <= 1'b0;
      wen_q    <= 1'b0;
      ren_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      wen_q <= 1'b0;
      ren_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (mvalid) begin
            addr_q <= addr_d;
            mode_q <= smode;
            busy_q <= 1'b1;
            if (ADDR_WIDTH == 1) begin
              cnt_q <= '0;
              if (smode == MODE_WRITE) begin
                state_q <= S_WDATA;
              end else begin
                state_q <= S_MEMRD;
                ren_q   <= 1'b1;
              end
            end else begin
              cnt_q   <= CNT_ONE;
              state_q <= S_ADDR;
            end
          end
        end

        S_ADDR: begin
          if (!mvalid) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            addr_q <= addr_d;
            if (cnt_q == ADDR_LAST) begin
              cnt_q <= '0;
              if (mode_q == MODE_WRITE) begin
                state_q <= S_WDATA;
              end else begin
                state_q <= S_MEMRD;
                ren_q   <= 1'b1;
              end
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
        end

        S_WDATA: begin
          if (!mvalid) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            wdata_q <= wdata_d;
            if (cnt_q == DATA_LAST) begin
              cnt_q   <= '0;
              state_q <= S_MEMWR;
              wen_q   <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
        end

        S_MEMWR: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end

        S_MEMRD: begin
          state_q <= S_RWAIT;
        end

        S_RWAIT: begin
          if (smemrvalid) begin
            rdata_q  <= smemrdata;
            srdata_q <= smemrdata[0];
            svalid_q <= 1'b1;
            cnt_q    <= '0;
            state_q  <= S_RDATA;
          end
        end

        S_RDATA: begin
          if (cnt_q == DATA_LAST) begin
            srdata_q <= 1'b0;
            svalid_q <= 1'b0;
            cnt_q    <= '0;
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
          end else begin
            rdata_q  <= rdata_d;
            srdata_q <= rdata_d[0];
            cnt_q    <= cnt_q + CNT_ONE;
          end
        end

        default: begin
          state_q  <= S_IDLE;
          cnt_q    <= '0;
          srdata_q <= 1'b0;
          svalid_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign srdata    = srdata_q;
  assign svalid    = svalid_q;
  assign smemaddr  = addr_q;
  assign smemwdata = wdata_q;
  assign smemwen   = wen_q;
  assign smemren   = ren_q;
  assign sbusy     = busy_q;

endmodule

// File: tb/tb_slave_port.sv
// Directed bench for slave_port: writes, reads at several device latencies,
// aborts, asynchronous reset mid-read and a back-to-back write/read.
module tb_slave_port;

  logic        clk = 1'b0;
  logic        rst;
  logic        swdata;
  logic        smode;
  logic        mvalid;
  logic        srdata;
  logic        svalid;
  logic [11:0] smemaddr;
  logic [7:0]  smemwdata;
  logic        smemwen;
  logic        smemren;
  logic [7:0]  smemrdata;
  logic        smemrvalid;
  logic        sbusy;

  int tests_run    = 0;
  int tests_failed = 0;
  int wen_cnt      = 0;
  int ren_cnt      = 0;
  logic [7:0] last_wr_data = 8'h00;

  slave_port #(.ADDR_WIDTH(12), .DATA_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .swdata     (swdata),
    .smode      (smode),
    .mvalid     (mvalid),
    .srdata     (srdata),
    .svalid     (svalid),
    .smemaddr   (smemaddr),
    .smemwdata  (smemwdata),
    .smemwen    (smemwen),
    .smemren    (smemren),
    .smemrdata  (smemrdata),
    .smemrvalid (smemrvalid),
    .sbusy      (sbusy)
  );

  always #5 clk = ~clk;

  // Device-side observer: counts enable pulses and remembers the last write.
  always @(posedge clk) begin
    if (smemwen) begin
      wen_cnt      <= wen_cnt + 1;
      last_wr_data <= smemwdata;
    end
    if (smemren) ren_cnt <= ren_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_xfer(input logic [11:0] addr, input logic [7:0] data);
    int wen0 = wen_cnt;
    int ren0 = ren_cnt;
    logic [19:0] stream = {data, addr};
    for (int i = 0; i < 20; i++) begin
      mvalid = 1'b1;
      smode  = (i == 0) ? 1'b1 : 1'b0;
      swdata = stream[i];
      tick();
      if (i == 0) check("wr_busy_start", sbusy, 1);
    end
    mvalid = 1'b0;
    swdata = 1'b0;
    check("wr_wen", smemwen, 1);
    check("wr_addr", smemaddr, addr);
    check("wr_data", smemwdata, data);
    tick();
    check("wr_wen_pulse", smemwen, 0);
    check("wr_idle", sbusy, 0);
    check("wr_wen_count", wen_cnt - wen0, 1);
    check("wr_no_ren", ren_cnt - ren0, 0);
    $display("[TB] write addr=0x%03h data=0x%02h", addr, data);
  endtask

  task automatic read_xfer(input logic [11:0] addr, input int lat, input logic [7:0] dev,
                           input logic [7:0] exp, input bit stray, input int rst_at);
    int wen0 = wen_cnt;
    int ren0 = ren_cnt;
    logic [7:0] got = 8'h00;
    for (int i = 0; i < 12; i++) begin
      mvalid     = 1'b1;
      smode      = (i == 0) ? 1'b0 : 1'b1;
      swdata     = addr[i];
      smemrvalid = stray && (i == 3);
      smemrdata  = 8'hFF;
      tick();
    end
    mvalid = 1'b0;
    swdata = 1'b0;
    smode  = 1'b0;
    check("rd_ren", smemren, 1);
    check("rd_addr", smemaddr, addr);
    smemrvalid = stray;
    smemrdata  = 8'hE7;
    for (int k = 1; k <= lat; k++) begin
      tick();
      smemrvalid = (k == lat);
      smemrdata  = (k == lat) ? dev : 8'h00;
      if (k == 1) check("rd_ren_pulse", smemren, 0);
      check("rd_wait", {sbusy, svalid}, 2'b10);
    end
    tick();
    smemrvalid = 1'b0;
    smemrdata  = ~dev;
    for (int i = 0; i < 8; i++) begin
      check("rd_bit", {svalid, srdata}, {1'b1, exp[i]});
      got[i] = srdata;
      if (rst_at == i) begin
        #2 rst = 1'b1;
        #1 check("rst_async", {svalid, srdata, sbusy}, 3'b000);
        @(posedge clk);
        #1 rst = 1'b0;
        check("rst_no_mem", (wen_cnt - wen0) + (ren_cnt - ren0), 1);
        $display("[TB] read addr=0x%03h reset at bit %0d", addr, i);
        return;
      end
      smemrvalid = stray && (i == 2);
      smemrdata  = 8'hFF;
      tick();
    end
    smemrvalid = 1'b0;
    check("rd_word", got, exp);
    check("rd_done", {svalid, sbusy}, 2'b00);
    check("rd_ren_count", ren_cnt - ren0, 1);
    check("rd_no_wen", wen_cnt - wen0, 0);
    if (stray) begin
      smemrvalid = 1'b1;
      tick();
      smemrvalid = 1'b0;
      check("idle_stray", {sbusy, svalid}, 2'b00);
      tick();
    end
    $display("[TB] read addr=0x%03h latency=%0d data=0x%02h", addr, lat, got);
  endtask

  task automatic abort_xfer(input logic [19:0] stream, input int nbits);
    int wen0 = wen_cnt;
    int ren0 = ren_cnt;
    for (int i = 0; i < nbits; i++) begin
      mvalid = 1'b1;
      smode  = 1'b1;
      swdata = stream[i];
      tick();
    end
    check("ab_busy", sbusy, 1);
    mvalid = 1'b0;
    swdata = 1'b0;
    tick();
    check("ab_idle", sbusy, 0);
    tick();
    tick();
    check("ab_no_mem", (wen_cnt - wen0) + (ren_cnt - ren0), 0);
    $display("[TB] abort after %0d bits", nbits);
  endtask

  initial begin
    rst        = 1'b1;
    swdata     = 1'b0;
    smode      = 1'b0;
    mvalid     = 1'b0;
    smemrdata  = 8'h00;
    smemrvalid = 1'b0;
    #12;
    check("reset_outs", {svalid, srdata, sbusy, smemwen, smemren}, 5'b0);
    check("reset_addr", smemaddr, 12'h000);
    check("reset_wdata", smemwdata, 8'h00);
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    check("post_reset_idle", sbusy, 0);

    write_xfer(12'h5A3, 8'hC7);
    read_xfer(12'h0F0, 1, 8'h96, 8'h96, 1'b0, -1);
    read_xfer(12'hFFF, 5, 8'h01, 8'h01, 1'b1, -1);
    abort_xfer({8'h00, 12'hABC}, 6);
    abort_xfer({8'hFF, 12'h321}, 15);
    write_xfer(12'h001, 8'hAA);
    read_xfer(12'h0F0, 1, 8'h3C, 8'h3C, 1'b0, 3);
    read_xfer(12'h2A5, 2, 8'h5B, 8'h5B, 1'b0, -1);
    write_xfer(12'h123, 8'h55);
    read_xfer(12'h123, 3, last_wr_data, 8'h55, 1'b0, -1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
